alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised successor to the single-cycle combinational ALU: a registered execute unit with valid/ready handshakes on input and output.
- Executes the full RV32I integer op set in one cycle.
- Optionally executes unsigned/low multiply iteratively.
- Sits between decode (supplies `op_i`, operands, tag) and writeback; a downstream stall holds the result without loss.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8
- TAG_W, 5, width of sideband tag carried with each op (typically rd)

Ports:
- `clk_i`  in  1  clock, rising edge
- `res_i`  in  1  reset, asynchronous, active-high
- `in_valid_i`  in  1  request valid
- `in_ready_o`  out  1  unit can accept a request this cycle
- `op_i`  in  4  ALU operation code (package constants)
- `a_i`  in  XLEN  operand A (rs1)
- `b_i`  in  XLEN  operand B (rs2 or immediate)
- `tag_i`  in  TAG_W  sideband tag
- `out_valid_o`  out  1  result valid
- `out_ready_i`  in  1  consumer accepts result
- `result_o`  out  XLEN  result
- `zero_o`  out  1  result == 0
- `illegal_o`  out  1  op code was unsupported
- `tag_o`  out  TAG_W  tag of the op that produced `result_o`
- `busy_o`  out  1  iterative op in progress

Behaviour:
- **Reset.** `res_i` high clears, immediately and regardless of clock: `out_valid_o`=0, `result_o`=0, `zero_o`=0, `illegal_o`=0, `tag_o`=0, `busy_o`=0; FSM=IDLE. An in-flight op is discarded; after release `in_ready_o`=1.
- **Accept.** A request is accepted on a rising edge with `in_valid_i` && `in_ready_o`.
- **Op codes:**
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR
  - 0110 SRL, 0111 SRA, 1000 OR, 1001 AND
  - 1010 MUL (low XLEN bits), 1011 MULHU (high XLEN bits, unsigned)
  - 1100-1111 illegal
- **Arithmetic rules.**
  - ADD/SUB wrap modulo 2^XLEN.
  - Shift amount = `b_i`[log2(XLEN)-1:0]; upper bits of `b_i` are ignored.
  - SLT is signed, SLTU is unsigned; both produce 0 or 1 zero-extended.
  - SRA replicates `a_i`[XLEN-1].
- **Single-cycle ops.** Accepted at edge N; `out_valid_o`=1 with result, tag, `zero_o` and `illegal_o`=0 visible after edge N.
- **Illegal op.** Completes like a single-cycle op with `result_o`=0, `zero_o`=1, `illegal_o`=1.
- **Throughput.** `in_ready_o` = (state==IDLE) && (!`out_valid_o` || `out_ready_i`), giving one op per cycle when the consumer is ready.
- **Output hold.** `out_valid_o`=1 && `out_ready_i`=0 holds `result_o`, `tag_o`, `zero_o` and `illegal_o` stable; `in_ready_o`=0.
- **Simultaneous pop and accept.** The new result replaces the popped one in the same edge with no bubble. A pop with no accept clears `out_valid_o`.
- **FSM (states IDLE, MUL, DONE):**
  - IDLE -> MUL on accept of MUL/MULHU.
  - MUL: shift-add, one multiplier bit per cycle, counter 0..XLEN-1; `busy_o`=1, `in_ready_o`=0.
  - MUL -> DONE when counter == XLEN-1; the product is latched into the output register and `out_valid_o`=1 on that edge.
  - DONE -> IDLE on `out_ready_i`.
  - Latency of MUL/MULHU: XLEN+1 edges from accept to `out_valid_o`, i.e. 33 for XLEN=32.
- **`zero_o`** always reflects the registered result, including multiply results.

Optional Feature:
- Macro: `ALU_PIPE_MULDIV_EN`.
- **Defined:**
  - Adds op codes 1101 DIVU and 1110 REMU via restoring division, one quotient bit per cycle. Reuses the MUL state and counter, latency XLEN+1.
  - Divide by zero: DIVU = all ones, REMU = `a_i`; still full latency.
  - 1100 and 1111 remain illegal.
- **Undefined:** 1101 and 1110 are illegal; divider datapath absent.

Decomposition:
- Package `alu_pkg`:
  - op-code localparams (`ALU_ADD` ... `ALU_REMU`) and `ALU_OP_W`=4
  - FSM state typedef (IDLE/MUL/DONE)
  - `ALU_SHAMT_W` function of XLEN
- Single-cycle datapath as combinational sub-module `alu_comb` (`op`, `a`, `b` -> `res`, `illegal`). The top holds the handshake, FSM, iterative unit and output register.

Test Plan:
- **ADD/SUB wrap:** ADD `a`=0xFFFF_FFFF, `b`=1, `tag`=3 -> next cycle `result_o`=0, `zero_o`=1, `tag_o`=3. SUB `a`=0, `b`=1 -> 0xFFFF_FFFF.
- **Shifts/compares:** SRA `a`=0x8000_0000, `b`=0x21 -> 0xC000_0000 (shamt 1). SLT 0xFFFF_FFFF vs 1 -> 1. SLTU 0xFFFF_FFFF vs 1 -> 0.
- **Backpressure:** 4 back-to-back ADDs with `out_ready_i` low from cycle 2 for 3 cycles:
  - `in_ready_o` low during the stall
  - results held stable
  - all 4 results delivered in order, none lost or duplicated
- **MUL/MULHU:** MULHU `a`=`b`=0xFFFF_FFFF -> after 33 edges `result_o`=0xFFFF_FFFE. MUL on the same operands -> 0x0000_0001. `busy_o`=1 and `in_ready_o`=0 throughout.
- **Reset mid-multiply:** assert `res_i` asynchronously at iteration 10 -> outputs clear before the next edge. After release, a new ADD 2+3 -> 5 with no residue.
- **Illegal op / option:** op 1111 -> `illegal_o`=1, `result_o`=0.
  - With `ALU_PIPE_MULDIV_EN`: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFF_FFFF.
  - Without it: op 1101 -> `illegal_o`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and helpers for the alu_pipe execute unit.
// ALU_PIPE_MULDIV_EN adds the iterative DIVU/REMU ops.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_MUL   = 4'b1010;
  localparam logic [ALU_OP_W-1:0] ALU_MULHU = 4'b1011;
  localparam logic [ALU_OP_W-1:0] ALU_DIVU  = 4'b1101;
  localparam logic [ALU_OP_W-1:0] ALU_REMU  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } alu_state_e;

  function automatic int alu_shamt_w(input int xlen);
    return $clog2(xlen);
  endfunction

  // Ops executed by the multi-cycle shift-add / restoring-divide unit.
  function automatic logic is_iter_op(input logic [ALU_OP_W-1:0] op);
`ifdef ALU_PIPE_MULDIV_EN
    return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
    return (op == ALU_MUL) || (op == ALU_MULHU);
`endif
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle RV32I datapath; iterative op codes return 0 here and are
// finished by the top-level unit. Honours ALU_PIPE_MULDIV_EN for legality.
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic [XLEN-1:0]     res,
  output logic                illegal
);

  localparam int SHW = alu_shamt_w(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    res     = '0;
    illegal = 1'b0;
    case (op)
      ALU_ADD:   res = a + b;
      ALU_SUB:   res = a - b;
      ALU_SLL:   res = a << shamt;
      ALU_SLT:   res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  res = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:   res = a ^ b;
      ALU_SRL:   res = a >> shamt;
      ALU_SRA:   res = $unsigned($signed(a) >>> shamt);
      ALU_OR:    res = a | b;
      ALU_AND:   res = a & b;
      ALU_MUL, ALU_MULHU: res = '0;
`ifdef ALU_PIPE_MULDIV_EN
      ALU_DIVU, ALU_REMU: res = '0;
`endif
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered execute unit with valid/ready handshakes, iterative multiply and,
// when ALU_PIPE_MULDIV_EN is defined, iterative unsigned divide/remainder.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                clk_i,
  input  logic                res_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  input  logic [TAG_W-1:0]    tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [XLEN-1:0]     result_o,
  output logic                zero_o,
  output logic                illegal_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic                busy_o
);

  localparam int SHW = alu_shamt_w(XLEN);

  logic [XLEN-1:0]     comb_res;
  logic                comb_illegal;
  alu_state_e          state;
  logic [SHW-1:0]      cnt;
  logic [XLEN-1:0]     hi_q, lo_q, opnd_q;
  logic [ALU_OP_W-1:0] op_q;
  logic [TAG_W-1:0]    tag_q;
  logic [XLEN-1:0]     hi_d, lo_d, iter_res;
  logic [XLEN:0]       mul_sum;
  logic                accept, start_div;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .op      (op_i),
    .a       (a_i),
    .b       (b_i),
    .res     (comb_res),
    .illegal (comb_illegal)
  );

  assign in_ready_o = (state == IDLE) && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign start_div  = (op_i == ALU_DIVU) || (op_i == ALU_REMU);

`ifdef ALU_PIPE_MULDIV_EN
  logic [XLEN:0] div_shift, div_diff;
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
`endif

  // One iteration: {hi,lo} is the product/remainder-quotient pair in flight.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    iter_res = '0;
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    case (op_q)
`ifdef ALU_PIPE_MULDIV_EN
      ALU_DIVU, ALU_REMU: begin
        if (!div_diff[XLEN]) begin
          hi_d = div_diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end
`endif
      default: begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    endcase
    case (op_q)
      ALU_MULHU, ALU_REMU: iter_res = hi_d;
      default:             iter_res = lo_d;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      // NOTE: the iteration registers are reset too so nothing from an aborted op survives.
      state       <= IDLE;
      cnt         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      op_q        <= ALU_ADD;
      tag_q       <= '0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      zero_o      <= 1'b0;
      illegal_o   <= 1'b0;
      tag_o       <= '0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_iter_op(op_i)) begin
              state       <= MUL;
              busy_o      <= 1'b1;
              cnt         <= '0;
              op_q        <= op_i;
              tag_q       <= tag_i;
              hi_q        <= '0;
              opnd_q      <= start_div ? b_i : a_i;
              lo_q        <= start_div ? a_i : b_i;
              out_valid_o <= 1'b0;
            end else begin
              out_valid_o <= 1'b1;
              result_o    <= comb_res;
              zero_o      <= (comb_res == '0);
              illegal_o   <= comb_illegal;
              tag_o       <= tag_i;
            end
          end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
          end
        end
        MUL: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          cnt  <= cnt + SHW'(1);
          if (cnt == SHW'(XLEN-1)) begin
            state       <= DONE;
            busy_o      <= 1'b0;
            out_valid_o <= 1'b1;
            result_o    <= iter_res;
            zero_o      <= (iter_res == '0);
            illegal_o   <= 1'b0;
            tag_o       <= tag_q;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
